// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, 32x32 register file with write-back
// forwarding, and the ID/EX pipeline register with valid/ready flow control.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    output logic        if_ready,
    input  logic        ex_ready,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [31:0] id_rs1_data,
    output logic [31:0] id_rs2_data,
    output logic [31:0] id_imm,
    output logic [2:0]  id_funct3,
    output logic [3:0]  id_alu_op,
    output logic        id_src_a_pc,
    output logic        id_src_b_imm,
    output logic        id_reg_write,
    output logic        id_is_load,
    output logic        id_is_store,
    output logic        id_is_branch,
    output logic        id_is_jump,
    output logic        id_illegal
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_N  = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [2:0]        funct3;
        logic [3:0]        alu_op;
        logic              src_a_pc;
        logic              src_b_imm;
        logic              reg_write;
        logic              is_load;
        logic              is_store;
        logic              is_branch;
        logic              is_jump;
        logic              illegal;
    } idex_t;

    idex_t             id_q, id_d, dec;
    logic [XLEN-1:0]   rf_q [REG_N];
    logic              xfer;
    logic              legal;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

    // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_of = ALU_SLL;
            3'd2:    alu_of = ALU_SLT;
            3'd3:    alu_of = ALU_SLTU;
            3'd4:    alu_of = ALU_XOR;
            3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    assign if_ready = !id_q.valid || ex_ready;
    assign xfer     = if_valid && if_ready;

    assign opcode = if_instruction[6:0];
    assign funct3 = if_instruction[14:12];
    assign funct7 = if_instruction[31:25];

    assign imm_i = {{20{if_instruction[31]}}, if_instruction[31:20]};
    assign imm_s = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
    assign imm_b = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                    if_instruction[30:25], if_instruction[11:8], 1'b0};
    assign imm_u = {if_instruction[31:12], 12'b0};
    assign imm_j = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                    if_instruction[20], if_instruction[30:21], 1'b0};

    // Combinational decode of the offered instruction, including operand read.
    always_comb begin
        dec        = '0;
        legal      = 1'b1;
        dec.valid  = 1'b1;
        dec.pc     = if_pc;
        dec.rs1    = if_instruction[19:15];
        dec.rs2    = if_instruction[24:20];
        dec.rd     = if_instruction[11:7];
        dec.funct3 = funct3;
        case (opcode)
            OP_LUI: begin
                dec.imm = imm_u; dec.alu_op = ALU_PASSB;
                dec.src_b_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.src_a_pc = 1'b1;
                dec.src_b_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JAL: begin
                dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.src_a_pc = 1'b1;
                dec.is_jump = 1'b1; dec.reg_write = 1'b1;
            end
            OP_JALR: begin
                dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.src_a_pc = 1'b1;
                dec.is_jump = 1'b1; dec.reg_write = 1'b1;
                legal = (funct3 == 3'd0);
            end
            OP_BRANCH: begin
                dec.imm = imm_b; dec.is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec.alu_op = ALU_SUB;
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.src_b_imm = 1'b1;
                dec.is_load = 1'b1; dec.reg_write = 1'b1;
                legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OP_STORE: begin
                dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.src_b_imm = 1'b1;
                dec.is_store = 1'b1;
                legal = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
            end
            OP_OPIMM: begin
                dec.imm = imm_i; dec.src_b_imm = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = alu_of(funct3, (funct3 == 3'd5) && funct7[5]);
                if (funct3 == 3'd1) legal = (funct7 == F7_ZERO);
                if (funct3 == 3'd5) legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            end
            OP_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op = alu_of(funct3, funct7[5]);
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.illegal   = 1'b1;
            dec.reg_write = 1'b0;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
        if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        // Same-cycle write-back bypasses the register file read.
        if (dec.rs1 == 5'd0)                    dec.rs1_data = '0;
        else if (wb_we && (wb_rd == dec.rs1))   dec.rs1_data = wb_data;
        else                                    dec.rs1_data = rf_q[dec.rs1];
        if (dec.rs2 == 5'd0)                    dec.rs2_data = '0;
        else if (wb_we && (wb_rd == dec.rs2))   dec.rs2_data = wb_data;
        else                                    dec.rs2_data = rf_q[dec.rs2];
    end

    // ID/EX next state: flush beats transfer, transfer beats drain/hold.
    always_comb begin
        id_d = id_q;
        if (flush)         id_d.valid = 1'b0;
        else if (xfer)     id_d = dec;
        else if (ex_ready) id_d.valid = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) id_q <= '0;
        else     id_q <= id_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign id_valid     = id_q.valid;
    assign id_pc        = id_q.pc;
    assign id_rs1       = id_q.rs1;
    assign id_rs2       = id_q.rs2;
    assign id_rd        = id_q.rd;
    assign id_rs1_data  = id_q.rs1_data;
    assign id_rs2_data  = id_q.rs2_data;
    assign id_imm       = id_q.imm;
    assign id_funct3    = id_q.funct3;
    assign id_alu_op    = id_q.alu_op;
    assign id_src_a_pc  = id_q.src_a_pc;
    assign id_src_b_imm = id_q.src_b_imm;
    assign id_reg_write = id_q.reg_write;
    assign id_is_load   = id_q.is_load;
    assign id_is_store  = id_q.is_store;
    assign id_is_branch = id_q.is_branch;
    assign id_is_jump   = id_q.is_jump;
    assign id_illegal   = id_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, forwarding, stall, flush, reset.
module tb_decode_stage;

    logic        clk, rst;
    logic        if_valid, if_ready, ex_ready, flush, wb_we;
    logic [31:0] if_pc, if_instruction, wb_data;
    logic [4:0]  wb_rd;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic [3:0]  id_alu_op;
    logic        id_src_a_pc, id_src_b_imm, id_reg_write, id_is_load, id_is_store;
    logic        id_is_branch, id_is_jump, id_illegal;

    int checks = 0;
    int errors = 0;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_instruction(if_instruction),
        .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_funct3(id_funct3), .id_alu_op(id_alu_op), .id_src_a_pc(id_src_a_pc),
        .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .id_is_store(id_is_store), .id_is_branch(id_is_branch), .id_is_jump(id_is_jump),
        .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        if_valid = 1'b1; if_pc = pc; if_instruction = ins;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 0; if_pc = 0; if_instruction = 0; ex_ready = 1;
        flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
        checks++; if ({id_pc, id_imm, id_rd, id_alu_op, id_reg_write} !== '0) begin errors++; $display("FAIL reset_fields: pc %h imm %h rd %0d alu %0d rw %b expected all 0", id_pc, id_imm, id_rd, id_alu_op, id_reg_write); end
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", if_ready); end
    endtask

    task automatic test_addi();
        offer(32'h0, 32'h00500093);
        step();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b expected 1", id_valid); end
        checks++; if (id_rd !== 5'd1 || id_rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs: rd %0d rs1 %0d expected 1 0", id_rd, id_rs1); end
        checks++; if (id_imm !== 32'h5) begin errors++; $display("FAIL addi_imm: got %h expected 00000005", id_imm); end
        checks++; if (id_alu_op !== 4'd0 || id_src_b_imm !== 1'b1 || id_reg_write !== 1'b1) begin errors++; $display("FAIL addi_ctrl: alu %0d srcb %b rw %b expected 0 1 1", id_alu_op, id_src_b_imm, id_reg_write); end
    endtask

    task automatic test_store_branch_lui();
        offer(32'h4, 32'h0020A423);
        step();
        checks++; if (id_imm !== 32'h8 || id_is_store !== 1'b1 || id_reg_write !== 1'b0) begin errors++; $display("FAIL sw: imm %h st %b rw %b expected 00000008 1 0", id_imm, id_is_store, id_reg_write); end
        checks++; if (id_pc !== 32'h4 || id_funct3 !== 3'd2 || id_rs1 !== 5'd1 || id_rs2 !== 5'd2) begin errors++; $display("FAIL sw_fields: pc %h f3 %0d rs1 %0d rs2 %0d expected 4 2 1 2", id_pc, id_funct3, id_rs1, id_rs2); end
        offer(32'h8, 32'hFE000EE3);
        step();
        checks++; if (id_imm !== 32'hFFFFFFFC || id_is_branch !== 1'b1) begin errors++; $display("FAIL beq: imm %h br %b expected fffffffc 1", id_imm, id_is_branch); end
        checks++; if (id_funct3 !== 3'd0 || id_alu_op !== 4'd1 || id_reg_write !== 1'b0) begin errors++; $display("FAIL beq_ctrl: f3 %0d alu %0d rw %b expected 0 1 0", id_funct3, id_alu_op, id_reg_write); end
        offer(32'hC, 32'h123452B7);
        step();
        checks++; if (id_imm !== 32'h12345000 || id_alu_op !== 4'd10 || id_rd !== 5'd5) begin errors++; $display("FAIL lui: imm %h alu %0d rd %0d expected 12345000 10 5", id_imm, id_alu_op, id_rd); end
    endtask

    task automatic test_other_ops();
        offer(32'h10, 32'h00412303);  // lw x6,4(x2)
        step();
        checks++; if (id_is_load !== 1'b1 || id_reg_write !== 1'b1 || id_imm !== 32'h4 || id_rd !== 5'd6) begin errors++; $display("FAIL lw: ld %b rw %b imm %h rd %0d expected 1 1 00000004 6", id_is_load, id_reg_write, id_imm, id_rd); end
        offer(32'h14, 32'h008000EF);  // jal x1,8
        step();
        checks++; if (id_is_jump !== 1'b1 || id_src_a_pc !== 1'b1 || id_imm !== 32'h8 || id_reg_write !== 1'b1) begin errors++; $display("FAIL jal: j %b apc %b imm %h rw %b expected 1 1 00000008 1", id_is_jump, id_src_a_pc, id_imm, id_reg_write); end
        offer(32'h18, 32'h00000013);  // addi x0,x0,0
        step();
        checks++; if (id_reg_write !== 1'b0 || id_illegal !== 1'b0) begin errors++; $display("FAIL rd0: rw %b ill %b expected 0 0", id_reg_write, id_illegal); end
        offer(32'h1C, 32'h020000B3);  // funct7=1 on OP is not RV32I
        step();
        checks++; if (id_illegal !== 1'b1 || id_reg_write !== 1'b0) begin errors++; $display("FAIL bad_funct7: ill %b rw %b expected 1 0", id_illegal, id_reg_write); end
        offer(32'h20, 32'h0000007F);
        step();
        checks++; if (id_illegal !== 1'b1 || id_valid !== 1'b1) begin errors++; $display("FAIL illegal: ill %b valid %b expected 1 1", id_illegal, id_valid); end
        checks++; if ({id_reg_write, id_is_load, id_is_store, id_is_branch, id_is_jump} !== 5'b0) begin errors++; $display("FAIL illegal_flags: got %b expected 00000", {id_reg_write, id_is_load, id_is_store, id_is_branch, id_is_jump}); end
    endtask

    task automatic test_forward();
        offer(32'h24, 32'h001081B3);  // add x3,x1,x1
        wb_we = 1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
        step();
        wb_we = 0;
        checks++; if (id_rs1_data !== 32'hDEADBEEF || id_rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd: rs1 %h rs2 %h expected deadbeef deadbeef", id_rs1_data, id_rs2_data); end
        checks++; if (id_alu_op !== 4'd0 || id_src_b_imm !== 1'b0 || id_rd !== 5'd3) begin errors++; $display("FAIL add_ctrl: alu %0d srcb %b rd %0d expected 0 0 3", id_alu_op, id_src_b_imm, id_rd); end
        offer(32'h28, 32'h00008233);  // add x4,x1,x0
        step();
        checks++; if (id_rs1_data !== 32'hDEADBEEF || id_rs2_data !== 32'h0) begin errors++; $display("FAIL rf_read: rs1 %h rs2 %h expected deadbeef 00000000", id_rs1_data, id_rs2_data); end
        if_valid = 0; wb_we = 1; wb_rd = 5'd0; wb_data = 32'h12345678;
        step();
        wb_we = 0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain: valid %b expected 0", id_valid); end
        offer(32'h2C, 32'h000002B3);  // add x5,x0,x0
        step();
        checks++; if (id_rs1_data !== 32'h0 || id_rs2_data !== 32'h0) begin errors++; $display("FAIL x0: rs1 %h rs2 %h expected 0 0", id_rs1_data, id_rs2_data); end
    endtask

    task automatic test_stall();
        offer(32'h40, 32'h00500093);
        step();
        ex_ready = 0;
        offer(32'h44, 32'h123452B7);
        #1;
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", if_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h40 || id_imm !== 32'h5) begin errors++; $display("FAIL stall_hold%0d: rdy %b v %b pc %h imm %h expected 0 1 00000040 00000005", i, if_ready, id_valid, id_pc, id_imm); end
        end
        ex_ready = 1;
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready: got %b expected 1", if_ready); end
        step();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || id_imm !== 32'h12345000) begin errors++; $display("FAIL unstall_accept: v %b pc %h imm %h expected 1 00000044 12345000", id_valid, id_pc, id_imm); end
    endtask

    task automatic test_flush();
        offer(32'h50, 32'h00500093);
        step();
        ex_ready = 0; flush = 1;
        offer(32'h54, 32'h123452B7);
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_stall: valid %b expected 0", id_valid); end
        ex_ready = 1;
        offer(32'h58, 32'h123452B7);
        #1;
        checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", if_ready); end
        step();
        flush = 0; if_valid = 0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: valid %b pc %h expected 0", id_valid, id_pc); end
        step();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_later: valid %b pc %h expected 0", id_valid, id_pc); end
    endtask

    task automatic test_reset_mid_stall();
        offer(32'h60, 32'h001081B3);
        step();
        ex_ready = 0; if_valid = 0;
        step();
        rst = 1;
        #1;
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || if_ready !== 1'b1) begin errors++; $display("FAIL reset_stall: v %b pc %h rdy %b expected 0 0 1", id_valid, id_pc, if_ready); end
        step();
        rst = 0; ex_ready = 1;
        offer(32'h64, 32'h00008233);  // add x4,x1,x0: x1 was cleared
        step();
        checks++; if (id_valid !== 1'b1 || id_rs1_data !== 32'h0) begin errors++; $display("FAIL rf_reset: v %b rs1 %h expected 1 00000000", id_valid, id_rs1_data); end
    endtask

    initial begin
        clk = 0;
        test_reset();
        test_addi();
        test_store_branch_lui();
        test_other_ops();
        test_forward();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the RISC-V RV32I in-order pipeline, directly downstream of the fetch stage. It accepts a fetched instruction and its PC over a valid/ready handshake and decodes it: register indices, sign-extended immediate, ALU operation and control flags. It reads two operands from an integrated 32×32 register file, with write-back forwarding, and holds the result in the ID/EX pipeline register. It back-pressures fetch when execute stalls and discards its contents on a control-flow flush.

## Interface
- XLEN, 32, datapath and register width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch presents a valid instruction
- if_pc  in  32  PC of presented instruction
- if_instruction  in  32  instruction word
- if_ready  out  1  decode accepts this cycle
- ex_ready  in  1  execute accepts the ID/EX contents this cycle
- flush  in  1  discard in-flight and incoming instruction (taken branch/jump)
- wb_we  in  1  register-file write enable
- wb_rd  in  5  write-back destination index
- wb_data  in  32  write-back data
- id_valid  out  1  ID/EX register holds a valid instruction
- id_pc  out  32  PC of decoded instruction
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_rs1_data, id_rs2_data  out  32 each  operand values
- id_imm  out  32  sign-extended immediate (I/S/B/U/J)
- id_funct3  out  3  raw funct3 (branch condition / memory size)
- id_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- id_src_a_pc  out  1  ALU operand A = PC (AUIPC, JAL, JALR link)
- id_src_b_imm  out  1  ALU operand B = immediate
- id_reg_write, id_is_load, id_is_store, id_is_branch, id_is_jump, id_illegal  out  1 each  control flags

## Operation
- Transfer in: if_valid && if_ready. Handshake: if_ready = !id_valid || ex_ready (combinational).
- On transfer, decode if_instruction combinationally and capture all id_* fields; id_valid <= 1.
- Without transfer, if ex_ready is high, clear id_valid. If ex_ready is low, hold every id_* output unchanged.
- Supported opcodes: LUI (PASSB, U-imm), AUIPC (ADD, src_a_pc, U-imm), JAL (is_jump, J-imm), JALR (is_jump, I-imm), BRANCH (is_branch, SUB/SLT/SLTU by funct3, B-imm), LOAD (ADD, I-imm), STORE (ADD, S-imm, reg_write=0), OP-IMM, and OP (funct7[5] selects SUB/SRA).
- Any other opcode, or an invalid funct3/funct7 combination, sets id_illegal=1 and clears reg_write, is_load, is_store, is_branch and is_jump.
- id_reg_write is forced to 0 when rd=0.
- Register file: x0 always reads 0 and writes to it are ignored. A write with wb_we=1 happens on the rising edge.
- Read forwarding: if wb_we && wb_rd==rsN && rsN!=0 in the capture cycle, id_rsN_data takes wb_data.
- Flush: id_valid <= 0 next edge. Any instruction offered in the same cycle is dropped, even if if_ready=1. Flush has priority over transfer and stall. Register-file writes are unaffected.

## Timing
- Latency: 1 cycle from transfer to id_valid.
- Throughput: 1 instruction/cycle while ex_ready=1.
- Reset (async, immediate): id_valid=0, all id_* data/control outputs 0, all 32 registers 0.
- if_ready=1 during reset release.
- Reset mid-stall drops the held instruction.
- A write-back to a register already captured in ID/EX does not update id_rsN_data; the hazard unit downstream handles it.

## Test plan
- Reset, then offer 0x00500093 (addi x1,x0,5) at pc 0x0 -> next cycle id_valid=1, rd=1, rs1=0, imm=0x00000005, alu_op=0, src_b_imm=1, reg_write=1.
- Offer 0x0020A423 (sw x2,8(x1)) -> imm=0x00000008, is_store=1, reg_write=0. Offer 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, is_branch=1, funct3=0, alu_op=1.
- Offer 0x123452B7 (lui x5,0x12345) -> imm=0x12345000, alu_op=10, rd=5.
- Forwarding: wb_we=1, wb_rd=1, wb_data=0xDEADBEEF in the cycle 0x001081B3 (add x3,x1,x1) is accepted -> id_rs1_data=id_rs2_data=0xDEADBEEF. Later read of x1 -> 0xDEADBEEF. Write to x0 -> x0 still reads 0.
- Stall: ex_ready=0 for 3 cycles with id_valid=1 -> if_ready=0 and outputs stable. ex_ready=1 -> next offered instruction accepted.
- Flush during stall with a new instruction offered -> id_valid=0 next cycle, offered instruction never appears. Opcode 0x0000007F -> id_illegal=1, all write/memory flags 0.
